// File: rtl/alu_mult_seq.sv
// Sequential unsigned shift-and-add multiplier producing a 2N-bit product over N BUSY cycles.
// Optional early-exit build: define ALU_MULT_EARLY_EXIT_EN to leave BUSY once the remaining multiplier bits are zero.
`timescale 1ns/1ps

module alu_mult_seq #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   P,
    output logic             busy
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [2*N-1:0]   mcand_r;
    logic [N-1:0]     mult_r;
    logic [2*N-1:0]   acc_r;
    logic [2*N-1:0]   p_r;
    logic [CW-1:0]    count_r;

    logic [2*N-1:0]   addend_s;
    logic [2*N-1:0]   acc_sum_s;
    logic [N-1:0]     mult_shift_s;
    logic             last_step_s;
    logic             accept_s;
    logic             finish_s;

    // Partial-product add and the shifted multiplier for this step.
    always_comb begin
        addend_s     = {(2*N){1'b0}};
        if (mult_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {(2*N){1'b0}};
        end
        acc_sum_s    = acc_r + addend_s;
        mult_shift_s = {1'b0, mult_r[N-1:1]};
    end

    // Decide whether this BUSY edge is the final step.
    always_comb begin
        last_step_s = 1'b0;
`ifdef ALU_MULT_EARLY_EXIT_EN
        if ((count_r == LAST_COUNT) || (mult_shift_s == {N{1'b0}})) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
`else
        if (count_r == LAST_COUNT) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
`endif
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_step_s) begin
                    finish_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand load, shift/add step and result capture; count holds on the final step so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= {(2*N){1'b0}};
            mult_r  <= {N{1'b0}};
            acc_r   <= {(2*N){1'b0}};
            count_r <= {CW{1'b0}};
            p_r     <= {(2*N){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mcand_r <= {{N{1'b0}}, A};
                        mult_r  <= B;
                        acc_r   <= {(2*N){1'b0}};
                        count_r <= {CW{1'b0}};
                    end
                end
                ST_BUSY: begin
                    acc_r   <= acc_sum_s;
                    mcand_r <= {mcand_r[2*N-2:0], 1'b0};
                    mult_r  <= mult_shift_s;
                    if (finish_s) begin
                        p_r <= acc_sum_s;
                    end else begin
                        count_r <= count_r + ONE_COUNT;
                    end
                end
                ST_DONE: begin
                    p_r <= p_r;
                end
                default: begin
                    p_r <= p_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_BUSY);
    assign out_valid = (state_r == ST_DONE);
    assign P         = p_r;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq: directed operand pairs with hand-computed products and latencies.
`timescale 1ns/1ps

module tb_alu_mult_seq;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   A;
    logic [31:0]   B;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   P;
    logic          busy;

    typedef struct {
        logic [63:0] p;
        int          lat;
        longint      t_acc;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint last_acc_t = 0;
    int     last_lat   = 0;

    alu_mult_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Latency the DUT should show for a vector: early-exit value when that build is selected.
    function automatic int eff_lat(input int lat_early);
`ifdef ALU_MULT_EARLY_EXIT_EN
        return lat_early;
`else
        return N;
`endif
    endfunction

    // Present operands, wait (bounded) for the handshake and record the expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                         input int lat_early, input bit hold, input bit chk_spacing);
        int   n;
        exp_t e;
        A = a;
        B = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(posedge clk);
            e.p     = exp;
            e.lat   = eff_lat(lat_early);
            e.t_acc = $time;
            if (chk_spacing) begin
                chk("accept_spacing", 64'(($time - last_acc_t) / 10), 64'(last_lat + 2));
            end
            last_acc_t = $time;
            last_lat   = e.lat;
            sb.push_back(e);
            #1;
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    // Monitor: pop and compare on the first DONE cycle, then check P holds while stalled.
    initial begin : monitor
        logic        prev_valid;
        logic [63:0] held_p;
        exp_t        e;
        prev_valid = 1'b0;
        held_p     = 64'd0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_underflow: out_valid with P=%h but no product expected", P);
                    end else begin
                        e = sb.pop_front();
                        chk("product", P, e.p);
                        chk("latency", 64'(($time - e.t_acc - 5) / 10), 64'(e.lat));
                    end
                    held_p = P;
                end else begin
                    chk("P_hold", P, held_p);
                end
            end
            prev_valid = rst_n && out_valid;
        end
    end

    initial begin : stimulus
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = 32'd0;
        B         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_P",         P,              64'd0);

        // Basic product, in_ready back one cycle after DONE drains.
        issue(32'd3, 32'd5, 64'd15, 3, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
        chk("drain_in_ready",  64'(in_ready),  64'd1);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
        issue(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 2, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;

        // Consumer stall with junk operands and in_valid pulses while busy and done.
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h0000_0100, 64'h0000_0012_3456_7800, 9, 1'b0, 1'b0);
        A = 32'hDEAD_BEEF;
        B = 32'hCAFE_F00D;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            A = A + 32'd1;
            @(posedge clk);
            #1;
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready",  64'(in_ready),  64'd0);
            chk("stall_P",         P,              64'h0000_0012_3456_7800);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release", 64'(out_valid), 64'd0);

        // Reset ten cycles into BUSY discards the operation.
        issue(32'hDEAD_BEEF, 32'hFFFF_FFFF, 64'd0, 32, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_P",         P,              64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd1);
        chk("arst_busy",      64'(busy),      64'd0);
        sb.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(32'd7, 32'd9, 64'd63, 4, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;

        // Short multipliers (single-cycle when early exit is built in) and top-bit multiplier.
        issue(32'h0000_ABCD, 32'd0, 64'd0, 1, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
        issue(32'h0000_1234, 32'd1, 64'h0000_0000_0000_1234, 1, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
        issue(32'd5, 32'h8000_0000, 64'h0000_0002_8000_0000, 32, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high.
        issue(32'd10,        32'd10,        64'd100,                 4,  1'b1, 1'b0);
        issue(32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF, 17, 1'b1, 1'b1);
        issue(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 17, 1'b1, 1'b1);
        issue(32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, 2,  1'b0, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
